// File: rtl/vga_timing_pkg.sv
// Shared VGA raster constants, coordinate types and window helper.
// Imported by the sync generator and by the pixel renderer.
package vga_timing_pkg;

    localparam int H_DISPLAY = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;
    localparam int V_DISPLAY = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int X_MAX   = H_DISPLAY - 1;
    localparam int Y_MAX   = V_DISPLAY - 1;
    localparam int COORD_W = 10;

    typedef logic [COORD_W-1:0] coord_t;

    typedef struct packed {
        logic   hsync;
        logic   vsync;
        logic   video_on;
        coord_t x;
        coord_t y;
    } raster_t;

    // Compared as int so lo+len may reach 1024 without wrapping.
    function automatic logic in_window(coord_t c, int lo, int len);
        return (int'(c) >= lo) && (int'(c) < lo + len);
    endfunction

endpackage

// File: rtl/vga_mod_counter.sv
// Mod-N counter with enable; wrap_o pulses while enabled at N-1.
// Chained through wrap_o to build the divider and h/v counters.
module vga_mod_counter #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         en_i,
    output logic [W-1:0] cnt_o,
    output logic         wrap_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic         at_max;

    assign at_max = (cnt_q == W'(N - 1));
    assign wrap_o = en_i & at_max;
    assign cnt_o  = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (en_i) begin
            cnt_d = at_max ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing: pixel divider, h/v counters, syncs, coordinates.
// Define VGA_SYNC_OUTREG_EN to add one aligned output register stage.
module vga_sync_gen #(
    parameter int CLK_DIV   = 4,
    parameter int H_DISPLAY = vga_timing_pkg::H_DISPLAY,
    parameter int H_FRONT   = vga_timing_pkg::H_FRONT,
    parameter int H_SYNC    = vga_timing_pkg::H_SYNC,
    parameter int H_BACK    = vga_timing_pkg::H_BACK,
    parameter int V_DISPLAY = vga_timing_pkg::V_DISPLAY,
    parameter int V_FRONT   = vga_timing_pkg::V_FRONT,
    parameter int V_SYNC    = vga_timing_pkg::V_SYNC,
    parameter int V_BACK    = vga_timing_pkg::V_BACK,
    parameter bit SYNC_POL  = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       p_tick,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       frame_start
);

    import vga_timing_pkg::*;

    localparam int HT    = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int VT    = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int HS_LO = H_DISPLAY + H_FRONT;
    localparam int VS_LO = V_DISPLAY + V_FRONT;

    logic [DIV_W-1:0] div_q;
    logic             div_wrap;
    logic             h_wrap;
    logic             v_wrap;
    logic             tick;
    logic             vid;
    coord_t           h_q;
    coord_t           v_q;
    coord_t           h_d;
    coord_t           v_d;
    logic             hsync_q;
    logic             vsync_q;
    logic             fs_q;
    raster_t          base;

    vga_mod_counter #(.N(CLK_DIV), .W(DIV_W)) u_div (
        .clk_i  (clk),
        .rst_ni (reset),
        .en_i   (1'b1),
        .cnt_o  (div_q),
        .wrap_o (div_wrap)
    );

    vga_mod_counter #(.N(HT), .W(COORD_W)) u_h (
        .clk_i  (clk),
        .rst_ni (reset),
        .en_i   (div_wrap),
        .cnt_o  (h_q),
        .wrap_o (h_wrap)
    );

    vga_mod_counter #(.N(VT), .W(COORD_W)) u_v (
        .clk_i  (clk),
        .rst_ni (reset),
        .en_i   (h_wrap),
        .cnt_o  (v_q),
        .wrap_o (v_wrap)
    );

    assign tick = (div_q == DIV_W'(CLK_DIV - 1));

    // Next-state position, so the registered syncs line up with x/y.
    assign h_d = h_wrap ? '0 : h_q + COORD_W'(div_wrap);
    assign v_d = v_wrap ? '0 : v_q + COORD_W'(h_wrap);

    always_ff @(posedge clk) begin
        if (!reset) begin
            hsync_q <= ~SYNC_POL;
            vsync_q <= ~SYNC_POL;
            fs_q    <= 1'b0;
        end else begin
            hsync_q <= in_window(h_d, HS_LO, H_SYNC) ? SYNC_POL : ~SYNC_POL;
            vsync_q <= in_window(v_d, VS_LO, V_SYNC) ? SYNC_POL : ~SYNC_POL;
            fs_q    <= v_wrap;
        end
    end

    assign vid  = (int'(h_q) < H_DISPLAY) && (int'(v_q) < V_DISPLAY);
    assign base = '{hsync: hsync_q, vsync: vsync_q, video_on: vid,
                    x: h_q, y: v_q};

`ifdef VGA_SYNC_OUTREG_EN
    raster_t out_q;
    logic    tick_q;
    logic    fs_out_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            out_q    <= '{hsync: ~SYNC_POL, vsync: ~SYNC_POL,
                          video_on: 1'b0, x: '0, y: '0};
            tick_q   <= 1'b0;
            fs_out_q <= 1'b0;
        end else begin
            out_q    <= base;
            tick_q   <= tick;
            fs_out_q <= fs_q;
        end
    end

    assign hsync       = out_q.hsync;
    assign vsync       = out_q.vsync;
    assign video_on    = out_q.video_on;
    assign x           = out_q.x;
    assign y           = out_q.y;
    assign p_tick      = tick_q;
    assign frame_start = fs_out_q;
`else
    assign hsync       = base.hsync;
    assign vsync       = base.vsync;
    assign video_on    = base.video_on;
    assign x           = base.x;
    assign y           = base.y;
    assign p_tick      = tick;
    assign frame_start = fs_q;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench for vga_sync_gen: default timing plus two small rasters.
// Expected outputs derive from the cycle count since reset.
module tb_vga_sync_gen;

    typedef struct {
        int d;
        int hd, hf, hs, hb;
        int vd, vf, vs, vb;
        bit pol;
    } tcfg_t;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    logic       a_hs, a_vs, a_vo, a_pt, a_fs;
    logic [9:0] a_x, a_y;
    logic       b_hs, b_vs, b_vo, b_pt, b_fs;
    logic [9:0] b_x, b_y;
    logic       c_hs, c_vs, c_vo, c_pt, c_fs;
    logic [9:0] c_x, c_y;

    logic [24:0] got_a, got_b, got_c;
    assign got_a = {a_hs, a_vs, a_vo, a_pt, a_fs, a_x, a_y};
    assign got_b = {b_hs, b_vs, b_vo, b_pt, b_fs, b_x, b_y};
    assign got_c = {c_hs, c_vs, c_vo, c_pt, c_fs, c_x, c_y};

    vga_sync_gen u_a (
        .clk(clk), .reset(reset), .hsync(a_hs), .vsync(a_vs),
        .video_on(a_vo), .p_tick(a_pt), .x(a_x), .y(a_y),
        .frame_start(a_fs)
    );

    vga_sync_gen #(
        .CLK_DIV(2), .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_DISPLAY(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .SYNC_POL(1'b0)
    ) u_b (
        .clk(clk), .reset(reset), .hsync(b_hs), .vsync(b_vs),
        .video_on(b_vo), .p_tick(b_pt), .x(b_x), .y(b_y),
        .frame_start(b_fs)
    );

    vga_sync_gen #(
        .CLK_DIV(1), .H_DISPLAY(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_DISPLAY(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1), .SYNC_POL(1'b1)
    ) u_c (
        .clk(clk), .reset(reset), .hsync(c_hs), .vsync(c_vs),
        .video_on(c_vo), .p_tick(c_pt), .x(c_x), .y(c_y),
        .frame_start(c_fs)
    );

    tcfg_t       cfg [3];
    logic [24:0] qa[$];
    logic [24:0] qb[$];
    logic [24:0] qc[$];
    int          n;
    int          checks = 0;
    int          errors = 0;
    int          a_hs_act = 0;
    int          b_fs_cnt = 0;
    int          c_fs_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // {hsync, vsync, video_on, p_tick, frame_start, x, y} at state n
    function automatic logic [24:0] model(tcfg_t c, int n_i);
        int   ht, vt, m, p, h, v;
        logic hs, vs, vo, pt, fs;
`ifdef VGA_SYNC_OUTREG_EN
        if (n_i == 0) return {~c.pol, ~c.pol, 3'b000, 20'd0};
        m = n_i - 1;
`else
        m = n_i;
`endif
        ht = c.hd + c.hf + c.hs + c.hb;
        vt = c.vd + c.vf + c.vs + c.vb;
        p  = m / c.d;
        h  = p % ht;
        v  = (p / ht) % vt;
        pt = ((m % c.d) == c.d - 1);
        fs = (m > 0) && (m % c.d == 0) && (p % (ht * vt) == 0);
        hs = (h >= c.hd + c.hf && h < c.hd + c.hf + c.hs) ? c.pol : ~c.pol;
        vs = (v >= c.vd + c.vf && v < c.vd + c.vf + c.vs) ? c.pol : ~c.pol;
        vo = (h < c.hd) && (v < c.vd);
        return {hs, vs, vo, pt, fs, 10'(h), 10'(v)};
    endfunction

    task automatic step(input logic rst_n);
        reset = rst_n;
        n = rst_n ? n + 1 : 0;
        qa.push_back(model(cfg[0], n));
        qb.push_back(model(cfg[1], n));
        qc.push_back(model(cfg[2], n));
        @(posedge clk);
        #1;
        check($sformatf("A n=%0d", n), 32'(got_a), 32'(qa.pop_front()));
        check($sformatf("B n=%0d", n), 32'(got_b), 32'(qb.pop_front()));
        check($sformatf("C n=%0d", n), 32'(got_c), 32'(qc.pop_front()));
        if (!a_hs && n < 3200) a_hs_act++;
        if (b_fs) b_fs_cnt++;
        if (c_fs) c_fs_cnt++;
    endtask

    initial begin
        cfg[0] = '{4, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0};
        cfg[1] = '{2, 8, 2, 3, 2, 6, 1, 2, 1, 1'b0};
        cfg[2] = '{1, 4, 1, 2, 1, 3, 1, 1, 1, 1'b1};
        n = 0;
        reset = 1'b0;

        for (int i = 0; i < 3; i++) step(1'b0);
        for (int i = 0; i < 7000; i++) step(1'b1);

        // One line of hsync is 96 px * 4 clk; frames of 300 and 48 clk.
        check("A hsync clk count", 32'(a_hs_act), 32'd384);
        check("B frame_start count", 32'(b_fs_cnt), 32'd23);
        check("C frame_start count", 32'(c_fs_cnt), 32'd145);

        b_fs_cnt = 0;
        c_fs_cnt = 0;
        step(1'b0);
        check("B no fs on reset", 32'(b_fs), 32'd0);
        check("C no fs on reset", 32'(c_fs), 32'd0);
        for (int i = 0; i < 1500; i++) step(1'b1);
        check("B fs after restart", 32'(b_fs_cnt), 32'd5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
